dds_sweep_ctrl: RTL and testbench

- Phase-accumulator sequencer that drives the phase input of the DDS core.
- Produces a linear frequency sweep (chirp) per accepted configuration, in one of three modes: single, repeat-sawtooth or triangle.
- Emits one phase word per clock while running.
- Sits between the register/config interface and the DDS phase AXIS input; the DDS output pipeline is downstream and unaffected.

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_phase_acc.sv | 31 +++
 rtl/dds_sweep_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the DDS sweep controller.
//   state_t    : controller state (IDLE, RUN)
//   mode_t     : sweep mode codes as carried on cfg_mode
//   MODE_RSVD  : reserved mode code, behaves as a single sweep
//   is_single_mode() : true for codes that end after one leg
package dds_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2
    } mode_t;

    localparam logic [1:0] MODE_RSVD = 2'd3;

    function automatic logic is_single_mode(input logic [1:0] m);
        return (m == MODE_SINGLE) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: registered phase accumulator with synchronous load and
// enable. Reusable by any NCO-style block.
//   clk, reset : clock, synchronous active-high reset (phase -> 0)
//   load       : phase <= load_val (wins over en)
//   load_val   : value to load
//   en         : phase <= phase + inc, modulo 2^PHASE_DW
//   inc        : phase increment
//   phase      : registered accumulator value
module dds_phase_acc #(
    parameter int PHASE_DW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PHASE_DW-1:0] load_val,
    input  logic                en,
    input  logic [PHASE_DW-1:0] inc,
    output logic [PHASE_DW-1:0] phase
);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (load) begin
            phase <= load_val;
        end else if (en) begin
            phase <= phase + inc;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency sweep (chirp) sequencer feeding the DDS
// phase input. One phase word per clock while running; single, sawtooth or
// triangle sweeps.
//   clk, reset           : clock, synchronous active-high reset
//   cfg_*                : sweep configuration, accepted on cfg_valid & cfg_ready
//   stop                 : abort the running sweep
//   m_axis_phase_tdata   : phase word for the DDS
//   m_axis_phase_tvalid  : phase word valid (one per cycle in RUN)
//   freq_out             : increment belonging to the current sample
//   busy                 : sweep in progress
//   done                 : pulse on the last sample of a single sweep
//
// Config handshake: a transfer happens on a rising clk edge where cfg_valid
// and cfg_ready are both high; cfg_ready is high only in IDLE, so cfg_valid
// held during RUN simply waits until the first IDLE cycle. The phase output
// has no backpressure: tvalid is high on every RUN cycle.
//
// Every output is a flop. The registers always describe the sample being
// presented, and the next-sample logic looks one sample ahead; done is
// therefore decided when the final sample is loaded, so a stop seen while
// that sample is being loaded cancels both the sample and the done pulse.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_DW = 16,
    parameter int FREQ_DW  = 16,
    parameter int CNT_DW   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PHASE_DW-1:0] cfg_phase_init,
    input  logic [FREQ_DW-1:0]  cfg_f_start,
    input  logic [FREQ_DW-1:0]  cfg_f_step,
    input  logic [CNT_DW-1:0]   cfg_steps,
    input  logic [CNT_DW-1:0]   cfg_dwell,
    input  logic [1:0]          cfg_mode,
    input  logic                stop,
    output logic [PHASE_DW-1:0] m_axis_phase_tdata,
    output logic                m_axis_phase_tvalid,
    output logic [FREQ_DW-1:0]  freq_out,
    output logic                busy,
    output logic                done
);

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [FREQ_DW-1:0]  f_start_q, f_start_d;
    logic [FREQ_DW-1:0]  f_step_q, f_step_d;
    logic [CNT_DW-1:0]   steps_q, steps_d;
    logic [CNT_DW-1:0]   dwell_q, dwell_d;
    logic [FREQ_DW-1:0]  freq_q, freq_d;
    logic [CNT_DW-1:0]   step_idx_q, step_idx_d;
    logic [CNT_DW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic                dir_q, dir_d;          // 0 = up, 1 = down
    logic                tvalid_q, busy_q, cfg_ready_q, done_q;
    logic                done_d;
    logic                acc_load, acc_en;

    dds_phase_acc #(
        .PHASE_DW (PHASE_DW)
    ) u_phase_acc (
        .clk      (clk),
        .reset    (reset),
        .load     (acc_load),
        .load_val (cfg_phase_init),
        .en       (acc_en),
        .inc      (PHASE_DW'(freq_q)),
        .phase    (m_axis_phase_tdata)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        f_start_d   = f_start_q;
        f_step_d    = f_step_q;
        steps_d     = steps_q;
        dwell_d     = dwell_q;
        freq_d      = freq_q;
        step_idx_d  = step_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        dir_d       = dir_q;
        acc_load    = 1'b0;
        acc_en      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    mode_d      = cfg_mode;
                    f_start_d   = cfg_f_start;
                    f_step_d    = cfg_f_step;
                    steps_d     = cfg_steps;
                    dwell_d     = cfg_dwell;
                    freq_d      = cfg_f_start;
                    step_idx_d  = '0;
                    dwell_cnt_d = '0;
                    dir_d       = 1'b0;
                    acc_load    = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (stop) begin
                    state_d = IDLE;
                end else if (dwell_cnt_q < dwell_q) begin
                    dwell_cnt_d = dwell_cnt_q + CNT_DW'(1);
                end else begin
                    dwell_cnt_d = '0;
                    if (step_idx_q < steps_q) begin
                        step_idx_d = step_idx_q + CNT_DW'(1);
                        freq_d     = dir_q ? (freq_q - f_step_q) : (freq_q + f_step_q);
                    end else if (is_single_mode(mode_q)) begin
                        state_d = IDLE;
                    end else if (mode_q == MODE_SAW) begin
                        freq_d     = f_start_q;
                        step_idx_d = '0;
                    end else if (steps_q != '0) begin
                        // Triangle turn-around: the end point is not repeated,
                        // the first sample of the new leg is already one step in.
                        dir_d      = ~dir_q;
                        freq_d     = dir_q ? (freq_q + f_step_q) : (freq_q - f_step_q);
                        step_idx_d = CNT_DW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The upcoming sample is the final one of a single sweep.
        done_d = (state_d == RUN) && is_single_mode(mode_d) &&
                 (step_idx_d == steps_d) && (dwell_cnt_d == dwell_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            f_start_q   <= '0;
            f_step_q    <= '0;
            steps_q     <= '0;
            dwell_q     <= '0;
            freq_q      <= '0;
            step_idx_q  <= '0;
            dwell_cnt_q <= '0;
            dir_q       <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            f_start_q   <= f_start_d;
            f_step_q    <= f_step_d;
            steps_q     <= steps_d;
            dwell_q     <= dwell_d;
            freq_q      <= freq_d;
            step_idx_q  <= step_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            dir_q       <= dir_d;
            tvalid_q    <= (state_d == RUN);
            busy_q      <= (state_d == RUN);
            cfg_ready_q <= (state_d == IDLE);
            done_q      <= done_d;
        end
    end

    assign m_axis_phase_tvalid = tvalid_q;
    assign busy                = busy_q;
    assign cfg_ready           = cfg_ready_q;
    assign done                = done_q;
    assign freq_out            = freq_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: self-checking bench for dds_sweep_ctrl.
module tb_dds_sweep_ctrl;

    localparam int PW = 16;
    localparam int FW = 16;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_phase_init;
    logic [FW-1:0] cfg_f_start;
    logic [FW-1:0] cfg_f_step;
    logic [CW-1:0] cfg_steps;
    logic [CW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic          stop;
    logic [PW-1:0] m_axis_phase_tdata;
    logic          m_axis_phase_tvalid;
    logic [FW-1:0] freq_out;
    logic          busy;
    logic          done;

    dds_sweep_ctrl #(.PHASE_DW(PW), .FREQ_DW(FW), .CNT_DW(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_phase_init      (cfg_phase_init),
        .cfg_f_start         (cfg_f_start),
        .cfg_f_step          (cfg_f_step),
        .cfg_steps           (cfg_steps),
        .cfg_dwell           (cfg_dwell),
        .cfg_mode            (cfg_mode),
        .stop                (stop),
        .m_axis_phase_tdata  (m_axis_phase_tdata),
        .m_axis_phase_tvalid (m_axis_phase_tvalid),
        .freq_out            (freq_out),
        .busy                (busy),
        .done                (done)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [PW-1:0] exp_q[$];
    logic [FW-1:0] exp_f_q[$];

    // Frequency of sample n: the step index follows the mode's shape
    // (ramp, repeating ramp, bouncing ramp) and f = f_start + idx*f_step.
    function automatic logic [FW-1:0] model_freq(input logic [FW-1:0] fs, input logic [FW-1:0] fst,
                                                 input int steps, input int dwell,
                                                 input logic [1:0] mode, input int n);
        int s, k, idx;
        s = n / (dwell + 1);
        if (mode == 2'd1) begin
            idx = s % (steps + 1);
        end else if (mode == 2'd2) begin
            if (steps == 0) idx = 0;
            else begin
                k   = s % (2 * steps);
                idx = (k <= steps) ? k : (2 * steps - k);
            end
        end else begin
            idx = s;
        end
        return FW'(int'(fs) + idx * int'(fst));
    endfunction

    task automatic build_expect(input logic [PW-1:0] init, input logic [FW-1:0] fs,
                                input logic [FW-1:0] fst, input int steps, input int dwell,
                                input logic [1:0] mode, input int nsamp);
        logic [PW-1:0] ph;
        logic [FW-1:0] f;
        exp_q.delete();
        exp_f_q.delete();
        ph = init;
        for (int n = 0; n < nsamp; n++) begin
            f = model_freq(fs, fst, steps, dwell, mode, n);
            exp_q.push_back(ph);
            exp_f_q.push_back(f);
            ph = ph + PW'(f);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge where the first sample shows.
    task automatic send_cfg(input logic [PW-1:0] init, input logic [FW-1:0] fs,
                            input logic [FW-1:0] fst, input int steps, input int dwell,
                            input logic [1:0] mode);
        int tmo;
        cfg_phase_init = init;
        cfg_f_start    = fs;
        cfg_f_step     = fst;
        cfg_steps      = CW'(steps);
        cfg_dwell      = CW'(dwell);
        cfg_mode       = mode;
        cfg_valid      = 1'b1;
        tmo = 0;
        while (cfg_ready !== 1'b1 && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        checks++;
        if (tmo >= 50) begin
            errors++;
            $display("FAIL cfg_accept_timeout cfg_ready=%b required=1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
        cfg_phase_init = '0; cfg_f_start = '0; cfg_f_step = '0;
        cfg_steps = '0; cfg_dwell = '0; cfg_mode = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || m_axis_phase_tdata !== '0 || freq_out !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1)
            begin
                errors++;
                $display("FAIL reset tvalid=%b tdata=%h freq=%h busy=%b done=%b ready=%b required 0,0,0,0,0,1",
                         m_axis_phase_tvalid, m_axis_phase_tdata, freq_out, busy, done, cfg_ready);
            end
    endtask

    task automatic test_single_basic();
        logic [PW-1:0] td_tab[6];
        logic [FW-1:0] fr_tab[6];
        td_tab = '{16'h0000, 16'h0100, 16'h0200, 16'h0310, 16'h0420, 16'h0540};
        fr_tab = '{16'h0100, 16'h0100, 16'h0110, 16'h0110, 16'h0120, 16'h0120};
        send_cfg(16'h0000, 16'h0100, 16'h0010, 2, 1, 2'd0);
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== td_tab[n] ||
                freq_out !== fr_tab[n] || busy !== 1'b1 || cfg_ready !== 1'b0 ||
                done !== (n == 5)) begin
                errors++;
                $display("FAIL single n=%0d tvalid=%b tdata=%h/%h freq=%h/%h done=%b/%b ready=%b",
                         n, m_axis_phase_tvalid, m_axis_phase_tdata, td_tab[n], freq_out,
                         fr_tab[n], done, (n == 5), cfg_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end tvalid=%b ready=%b done=%b busy=%b required 0,1,0,0",
                     m_axis_phase_tvalid, cfg_ready, done, busy);
        end
    endtask

    task automatic test_triangle_stop();
        logic [FW-1:0] fr_tab[7];
        fr_tab = '{16'h10, 16'h20, 16'h30, 16'h20, 16'h10, 16'h20, 16'h30};
        build_expect(16'h0040, 16'h0010, 16'h0010, 2, 0, 2'd2, 7);
        send_cfg(16'h0040, 16'h0010, 16'h0010, 2, 0, 2'd2);
        for (int n = 0; n < 7; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || freq_out !== fr_tab[n] ||
                m_axis_phase_tdata !== exp_q[n] || done !== 1'b0) begin
                errors++;
                $display("FAIL triangle n=%0d tvalid=%b freq=%h/%h tdata=%h/%h done=%b",
                         n, m_axis_phase_tvalid, freq_out, fr_tab[n], m_axis_phase_tdata, exp_q[n], done);
            end
            if (n == 6) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL triangle_stop tvalid=%b done=%b ready=%b required 0,0,1",
                     m_axis_phase_tvalid, done, cfg_ready);
        end
    endtask

    task automatic test_saw_wrap();
        logic [FW-1:0] fr_tab[8];
        fr_tab = '{16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF};
        build_expect(16'hFFFF, 16'h0002, 16'hFFFF, 3, 0, 2'd1, 8);
        send_cfg(16'hFFFF, 16'h0002, 16'hFFFF, 3, 0, 2'd1);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || freq_out !== fr_tab[n] ||
                m_axis_phase_tdata !== exp_q[n] || done !== 1'b0) begin
                errors++;
                $display("FAIL saw n=%0d freq=%h/%h tdata=%h/%h done=%b",
                         n, freq_out, fr_tab[n], m_axis_phase_tdata, exp_q[n], done);
            end
            if (n == 1) begin
                checks++;
                if (m_axis_phase_tdata !== 16'h0001) begin
                    errors++;
                    $display("FAIL saw_phase_wrap tdata=%h required=0001", m_axis_phase_tdata);
                end
            end
            if (n == 7) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL saw_stop tvalid=%b done=%b required 0,0", m_axis_phase_tvalid, done);
        end
    endtask

    task automatic test_tone_single();
        send_cfg(16'h2468, 16'h0123, 16'h0004, 0, 0, 2'd0);
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h2468 ||
            freq_out !== 16'h0123 || done !== 1'b1) begin
            errors++;
            $display("FAIL tone tvalid=%b tdata=%h/2468 freq=%h/0123 done=%b/1",
                     m_axis_phase_tvalid, m_axis_phase_tdata, freq_out, done);
        end
        @(negedge clk);
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL tone_end tvalid=%b done=%b ready=%b required 0,0,1",
                     m_axis_phase_tvalid, done, cfg_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        build_expect(16'h1234, 16'h0101, 16'h0003, 5, 3, 2'd0, 3);
        send_cfg(16'h1234, 16'h0101, 16'h0003, 5, 3, 2'd0);
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_q[n] || freq_out !== exp_f_q[n]) begin
                errors++;
                $display("FAIL midrun n=%0d tdata=%h/%h freq=%h/%h",
                         n, m_axis_phase_tdata, exp_q[n], freq_out, exp_f_q[n]);
            end
            if (n == 2) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
            done !== 1'b0 || m_axis_phase_tdata !== '0 || freq_out !== '0) begin
            errors++;
            $display("FAIL midrun_reset tvalid=%b busy=%b ready=%b done=%b tdata=%h freq=%h required 0,0,1,0,0,0",
                     m_axis_phase_tvalid, busy, cfg_ready, done, m_axis_phase_tdata, freq_out);
        end
        build_expect(16'hABCD, 16'h0007, 16'h0001, 1, 0, 2'd0, 2);
        send_cfg(16'hABCD, 16'h0007, 16'h0001, 1, 0, 2'd0);
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_q[n] ||
                freq_out !== exp_f_q[n] || done !== (n == 1)) begin
                errors++;
                $display("FAIL restart n=%0d tdata=%h/%h freq=%h/%h done=%b",
                         n, m_axis_phase_tdata, exp_q[n], freq_out, exp_f_q[n], done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        build_expect(16'h0100, 16'h0020, 16'h0004, 1, 1, 2'd0, 4);
        send_cfg(16'h0100, 16'h0020, 16'h0004, 1, 1, 2'd0);
        // A second config is offered while the first sweep runs.
        cfg_phase_init = 16'h5555; cfg_f_start = 16'h0011; cfg_f_step = 16'h0001;
        cfg_steps = '0; cfg_dwell = '0; cfg_mode = 2'd0; cfg_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_q[n] ||
                freq_out !== exp_f_q[n] || cfg_ready !== 1'b0 || done !== (n == 3)) begin
                errors++;
                $display("FAIL b2b_first n=%0d tdata=%h/%h freq=%h/%h ready=%b done=%b",
                         n, m_axis_phase_tdata, exp_q[n], freq_out, exp_f_q[n], cfg_ready, done);
            end
            @(negedge clk);
        end
        checks++;
        if (m_axis_phase_tvalid !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap tvalid=%b ready=%b done=%b required 0,1,0", m_axis_phase_tvalid, cfg_ready, done);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h5555 ||
            freq_out !== 16'h0011 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second tvalid=%b tdata=%h/5555 freq=%h/0011 done=%b/1",
                     m_axis_phase_tvalid, m_axis_phase_tdata, freq_out, done);
        end
        @(negedge clk);
    endtask

    task automatic test_stop_cases();
        // Stop while the final sample is being loaded: no final sample, no done.
        send_cfg(16'h0200, 16'h0040, 16'h0008, 2, 0, 2'd0);
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h0200 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_s0 tvalid=%b tdata=%h/0200 done=%b", m_axis_phase_tvalid, m_axis_phase_tdata, done);
        end
        @(negedge clk);
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h0240 || freq_out !== 16'h0048) begin
            errors++;
            $display("FAIL stop_s1 tdata=%h/0240 freq=%h/0048", m_axis_phase_tdata, freq_out);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_phase_tvalid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL stop_end i=%0d tvalid=%b done=%b ready=%b required 0,0,1",
                         i, m_axis_phase_tvalid, done, cfg_ready);
            end
            @(negedge clk);
        end
        // Stop together with cfg_valid in IDLE: the config is accepted.
        stop = 1'b1;
        send_cfg(16'h0777, 16'h0003, 16'h0001, 0, 1, 2'd3);
        stop = 1'b0;
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h0777 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle_s0 tvalid=%b tdata=%h/0777 done=%b", m_axis_phase_tvalid, m_axis_phase_tdata, done);
        end
        @(negedge clk);
        checks++;
        if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'h077A || done !== 1'b1) begin
            errors++;
            $display("FAIL stop_idle_s1 tvalid=%b tdata=%h/077a done=%b/1", m_axis_phase_tvalid, m_axis_phase_tdata, done);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [PW-1:0] init;
        logic [FW-1:0] fs, fst;
        logic [1:0]    mode;
        int            steps, dwell, nsamp;
        logic          single;
        for (int t = 0; t < 8; t++) begin
            init   = PW'($urandom_range(0, 65535));
            fs     = FW'($urandom_range(0, 65535));
            fst    = FW'($urandom_range(0, 65535));
            steps  = $urandom_range(0, 4);
            dwell  = $urandom_range(0, 2);
            mode   = 2'($urandom_range(0, 3));
            single = (mode == 2'd0) || (mode == 2'd3);
            nsamp  = single ? (steps + 1) * (dwell + 1) : $urandom_range(4, 20);
            build_expect(init, fs, fst, steps, dwell, mode, nsamp);
            send_cfg(init, fs, fst, steps, dwell, mode);
            for (int n = 0; n < nsamp; n++) begin
                checks++;
                if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== exp_q[n] ||
                    freq_out !== exp_f_q[n] || busy !== 1'b1 ||
                    done !== (single && n == nsamp - 1)) begin
                    errors++;
                    $display("FAIL random t=%0d mode=%0d n=%0d tvalid=%b tdata=%h/%h freq=%h/%h done=%b",
                             t, mode, n, m_axis_phase_tvalid, m_axis_phase_tdata, exp_q[n],
                             freq_out, exp_f_q[n], done);
                end
                if (!single && n == nsamp - 1) stop = 1'b1;
                @(negedge clk);
            end
            stop = 1'b0;
            checks++;
            if (m_axis_phase_tvalid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_end t=%0d tvalid=%b done=%b ready=%b required 0,0,1",
                         t, m_axis_phase_tvalid, done, cfg_ready);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_basic();
        test_triangle_stop();
        test_saw_wrap();
        test_tone_single();
        test_reset_mid_run();
        test_back_to_back();
        test_stop_cases();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
